// File: rtl/ysyx_22050368_pc_gen_pkg.sv
// Shared constants for the PC generator: bus widths, hold codes,
// reset vector and FSM encodings.
package ysyx_22050368_pc_gen_pkg;

  localparam int INST_ADDR_W = 64;
  localparam int HOLD_FLAG_W = 3;

  localparam logic [2:0] HOLD_NONE = 3'd0;
  localparam logic [2:0] HOLD_PC   = 3'd1;
  localparam logic [2:0] HOLD_IF   = 3'd2;
  localparam logic [2:0] HOLD_ID   = 3'd3;

  localparam logic [63:0] RESET_PC_DEF =
    64'h0000_0000_8000_0000;

  typedef enum logic [2:0] {
    ST_HALT  = 3'd0,
    ST_BOOT  = 3'd1,
    ST_RUN   = 3'd2,
    ST_STALL = 3'd3,
    ST_TRAP  = 3'd4
  } pc_state_e;

  // A fetch target must be word aligned.
  function automatic logic misaligned(
    input logic [1:0] lo
  );
    return lo != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_22050368_pc_gen.sv
// Program counter owner: issues fetch addresses to the IFU and
// handles redirects, holds, debug reset and a fetch counter.
module ysyx_22050368_pc_gen
  import ysyx_22050368_pc_gen_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC =
    ADDR_W'(RESET_PC_DEF),
  parameter int HOLD_W = HOLD_FLAG_W,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_flag_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic [HOLD_W-1:0] hold_flag_i,
  input  logic              jtag_reset_flag_i,
  input  logic              pc_ready_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              pc_valid_o,
  output logic              misalign_o,
  output logic [CNT_W-1:0]  fetch_cnt_o
);

  pc_state_e         state_q, state_n;
  logic [ADDR_W-1:0] pc_q, pc_n;
  logic              valid_q, valid_n;
  logic              mis_q, mis_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic              fire;
  logic              hold;

  assign fire = valid_q & pc_ready_i;
  assign hold = hold_flag_i >= HOLD_W'(HOLD_PC);

  // Next state with priority jtag > jump > hold > fire.
  always_comb begin
    state_n = state_q;
    pc_n    = pc_q;
    mis_n   = mis_q;
    cnt_n   = cnt_q;
    if (jtag_reset_flag_i) begin
      state_n = ST_HALT;
      pc_n    = RESET_PC;
      mis_n   = 1'b0;
    end else if (state_q == ST_HALT) begin
      state_n = ST_BOOT;
    end else if (jump_flag_i) begin
      pc_n  = jump_addr_i;
      cnt_n = cnt_q + CNT_W'(fire);
      if (misaligned(jump_addr_i[1:0])) begin
        state_n = ST_TRAP;
        mis_n   = 1'b1;
      end else begin
        mis_n   = 1'b0;
        state_n = hold ? ST_STALL : ST_RUN;
      end
    end else begin
      unique case (state_q)
        ST_BOOT: state_n = ST_RUN;
        ST_RUN: begin
          if (fire) begin
            pc_n  = pc_q + ADDR_W'(4);
            cnt_n = cnt_q + CNT_W'(1);
          end
          if (hold) state_n = ST_STALL;
        end
        ST_STALL: begin
          if (!hold) state_n = ST_RUN;
        end
        ST_TRAP: state_n = ST_TRAP;
        default: state_n = ST_BOOT;
      endcase
    end
    valid_n = state_n == ST_RUN;
  end

  // Architectural registers; all outputs come straight from here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      pc_q    <= pc_n;
      valid_q <= valid_n;
      mis_q   <= mis_n;
      cnt_q   <= cnt_n;
    end
  end

  assign pc_o        = pc_q;
  assign pc_valid_o  = valid_q;
  assign misalign_o  = mis_q;
  assign fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_ysyx_22050368_pc_gen.sv
// Self-checking bench for the PC generator: directed scenarios
// followed by random traffic against a behavioural model.
module tb_ysyx_22050368_pc_gen;

  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

  logic        clk;
  logic        rst;
  logic        jump_flag_i;
  logic [63:0] jump_addr_i;
  logic [2:0]  hold_flag_i;
  logic        jtag_reset_flag_i;
  logic        pc_ready_i;
  logic [63:0] pc_o;
  logic        pc_valid_o;
  logic        misalign_o;
  logic [31:0] fetch_cnt_o;

  int checks = 0;
  int errors = 0;

  // model: the PC, counter, flags, and which "mode" we are in
  logic [63:0] m_pc;
  logic [31:0] m_cnt;
  logic        m_valid;
  logic        m_mis;
  bit          m_halt, m_boot, m_stall, m_trap;

  ysyx_22050368_pc_gen dut (
    .clk               (clk),
    .rst               (rst),
    .jump_flag_i       (jump_flag_i),
    .jump_addr_i       (jump_addr_i),
    .hold_flag_i       (hold_flag_i),
    .jtag_reset_flag_i (jtag_reset_flag_i),
    .pc_ready_i        (pc_ready_i),
    .pc_o              (pc_o),
    .pc_valid_o        (pc_valid_o),
    .misalign_o        (misalign_o),
    .fetch_cnt_o       (fetch_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: sim time exceeded");
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    m_pc = RPC; m_cnt = '0; m_valid = 1'b0; m_mis = 1'b0;
    m_halt = 0; m_boot = 1; m_stall = 0; m_trap = 0;
  endtask

  // One clock edge of the spec's behaviour, using pre-edge values.
  task automatic model_step();
    bit fire;
    bit hold;
    fire = m_valid && pc_ready_i;
    hold = hold_flag_i >= 3'd1;
    if (jtag_reset_flag_i) begin
      m_pc = RPC; m_mis = 1'b0;
      m_halt = 1; m_boot = 0; m_stall = 0; m_trap = 0;
    end else if (m_halt) begin
      m_halt = 0; m_boot = 1;
    end else if (jump_flag_i) begin
      if (fire) m_cnt = m_cnt + 1;
      m_pc = jump_addr_i;
      m_boot = 0;
      if (jump_addr_i % 4 != 0) begin
        m_trap = 1; m_mis = 1'b1; m_stall = 0;
      end else begin
        m_trap = 0; m_mis = 1'b0; m_stall = hold;
      end
    end else if (m_boot) begin
      m_boot = 0;
    end else if (m_trap) begin
      m_trap = 1;
    end else if (m_stall) begin
      m_stall = hold;
    end else begin
      if (fire) begin
        m_pc = m_pc + 64'd4;
        m_cnt = m_cnt + 1;
      end
      m_stall = hold;
    end
    m_valid = !(m_halt || m_boot || m_stall || m_trap);
  endtask

  task automatic chk64(string tag, logic [63:0] got,
                       logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic check_model(string tag);
    chk64({tag, ".pc"}, pc_o, m_pc);
    chk64({tag, ".valid"}, 64'(pc_valid_o), 64'(m_valid));
    chk64({tag, ".mis"}, 64'(misalign_o), 64'(m_mis));
    chk64({tag, ".cnt"}, 64'(fetch_cnt_o), 64'(m_cnt));
  endtask

  task automatic cyc(string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic idle_inputs();
    jump_flag_i = 1'b0;
    jump_addr_i = '0;
    hold_flag_i = 3'd0;
    jtag_reset_flag_i = 1'b0;
  endtask

  initial begin
    logic [63:0] a;
    logic [31:0] saved_cnt;
    rst = 1'b0;
    pc_ready_i = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    check_model("reset");
    chk64("reset.pc_const", pc_o, RPC);

    // release reset: BOOT, then a new fetch every cycle
    rst = 1'b1;
    cyc("boot1");
    chk64("boot1.pc_const", pc_o, RPC);
    chk64("boot1.valid_const", 64'(pc_valid_o), 64'd1);
    cyc("run1");
    cyc("run2");
    chk64("run2.pc_const", pc_o, 64'h8000_0008);
    chk64("run2.cnt_const", 64'(fetch_cnt_o), 64'd2);

    // IFU back-pressure
    pc_ready_i = 1'b0;
    repeat (3) cyc("noready");
    chk64("noready.pc_const", pc_o, 64'h8000_0008);
    chk64("noready.valid_const", 64'(pc_valid_o), 64'd1);
    pc_ready_i = 1'b1;
    cyc("resume");
    chk64("resume.pc_const", pc_o, 64'h8000_000c);

    // jump coinciding with a hold
    hold_flag_i = 3'd1;
    jump_flag_i = 1'b1;
    jump_addr_i = 64'h8000_1000;
    cyc("jhold");
    chk64("jhold.pc_const", pc_o, 64'h8000_1000);
    chk64("jhold.valid_const", 64'(pc_valid_o), 64'd0);
    jump_flag_i = 1'b0;
    cyc("jhold2");
    hold_flag_i = 3'd0;
    cyc("release");
    chk64("release.valid_const", 64'(pc_valid_o), 64'd1);

    // misaligned redirect traps until an aligned jump
    pc_ready_i = 1'b0;
    jump_flag_i = 1'b1;
    jump_addr_i = 64'h8000_0102;
    cyc("mis");
    chk64("mis.flag_const", 64'(misalign_o), 64'd1);
    jump_flag_i = 1'b0;
    hold_flag_i = 3'd3;
    pc_ready_i = 1'b1;
    repeat (2) cyc("trap");
    hold_flag_i = 3'd0;
    jump_flag_i = 1'b1;
    jump_addr_i = 64'h8000_0200;
    cyc("unmis");
    chk64("unmis.pc_const", pc_o, 64'h8000_0200);
    chk64("unmis.flag_const", 64'(misalign_o), 64'd0);

    // debug reset preserves the counter
    jump_addr_i = 64'h8000_0040;
    pc_ready_i = 1'b0;
    cyc("tojtag");
    jump_flag_i = 1'b0;
    saved_cnt = m_cnt;
    jtag_reset_flag_i = 1'b1;
    repeat (2) cyc("jtag");
    chk64("jtag.pc_const", pc_o, RPC);
    chk64("jtag.cnt_kept", 64'(fetch_cnt_o), 64'(saved_cnt));
    jtag_reset_flag_i = 1'b0;
    pc_ready_i = 1'b1;
    cyc("halt2boot");
    chk64("halt2boot.valid_const", 64'(pc_valid_o), 64'd0);
    cyc("boot2run");
    chk64("boot2run.valid_const", 64'(pc_valid_o), 64'd1);

    // address wrap at the top of the space
    jump_flag_i = 1'b1;
    jump_addr_i = 64'hFFFF_FFFF_FFFF_FFFC;
    pc_ready_i = 1'b0;
    cyc("towrap");
    jump_flag_i = 1'b0;
    pc_ready_i = 1'b1;
    cyc("wrap");
    chk64("wrap.pc_const", pc_o, 64'h0);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      pc_ready_i = 1'($urandom_range(0, 1));
      jtag_reset_flag_i = ($urandom_range(0, 39) == 0);
      jump_flag_i = ($urandom_range(0, 7) == 0);
      a = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) a[63:8] = '1;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      jump_addr_i = a;
      hold_flag_i = ($urandom_range(0, 4) == 0) ?
        3'($urandom_range(1, 7)) : 3'd0;
      cyc("rand");
    end

    // asynchronous reset mid-cycle
    idle_inputs();
    pc_ready_i = 1'b1;
    repeat (3) cyc("prearst");
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_model("arst");
    chk64("arst.cnt_const", 64'(fetch_cnt_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) cyc("postarst");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
